// File: rtl/tail_light_decoder_if.sv
// Lamp pattern from the turn-signal FSM plus the decoded mode and status it produces.
// master drives the lamp pattern; slave is the decoder that reports on it.
interface tail_light_decoder_if #(
  parameter int CNT_W = 8
);
  logic [5:0]       y;
  logic [1:0]       mode;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  modport master (output y, input mode, done, err, err_cnt);
  modport slave  (input y, output mode, done, err, err_cnt);
endinterface

// File: rtl/tail_light_decoder.sv
// Decodes the tail-light pattern {LC,LB,LA,RA,RB,RC} into off/left/right/hazard and flags illegal patterns or orderings.
// All outputs registered, valid one clock after the deciding sample; passive observer with no backpressure.
module tail_light_decoder #(
  parameter int OFF_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  tail_light_decoder_if.slave  tl
);

  localparam logic [3:0] ST_SYNC = 4'd0;
  localparam logic [3:0] ST_IDLE = 4'd1;
  localparam logic [3:0] ST_L1   = 4'd2;
  localparam logic [3:0] ST_L2   = 4'd3;
  localparam logic [3:0] ST_L3   = 4'd4;
  localparam logic [3:0] ST_R1   = 4'd5;
  localparam logic [3:0] ST_R2   = 4'd6;
  localparam logic [3:0] ST_R3   = 4'd7;
  localparam logic [3:0] ST_H1   = 4'd8;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_HAZ   = 2'b11;

  localparam logic [5:0] P_DARK = 6'b000000;
  localparam logic [5:0] P_L1   = 6'b001000;
  localparam logic [5:0] P_L2   = 6'b011000;
  localparam logic [5:0] P_L3   = 6'b111000;
  localparam logic [5:0] P_R1   = 6'b000100;
  localparam logic [5:0] P_R2   = 6'b000110;
  localparam logic [5:0] P_R3   = 6'b000111;
  localparam logic [5:0] P_HAZ  = 6'b111111;

  localparam logic [3:0]       OFF_LAST = 4'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       state_q, state_d;
  logic [3:0]       dark_q, dark_d;
  logic [1:0]       mode_q, mode_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       in_seq;
  logic       fin;
  logic       flag_err;
  logic [5:0] exp_pat;
  logic [3:0] nxt_state;
  logic [1:0] fin_mode;
  logic [3:0] dark_inc;

  always_comb begin
    state_d   = state_q;
    dark_d    = dark_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    in_seq    = 1'b0;
    fin       = 1'b0;
    flag_err  = 1'b0;
    exp_pat   = P_DARK;
    nxt_state = ST_IDLE;
    fin_mode  = mode_q;
    dark_inc  = dark_q + 4'd1;

    case (state_q)
      ST_SYNC: begin
        if (tl.y == P_DARK) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        case (tl.y)
          P_DARK: begin
            if (dark_q != OFF_LAST) begin
              dark_d = dark_inc;
              if (dark_inc == OFF_LAST) mode_d = MODE_OFF;
            end
          end
          P_L1:    state_d = ST_L1;
          P_R1:    state_d = ST_R1;
          P_HAZ:   state_d = ST_H1;
          default: flag_err = 1'b1;
        endcase
      end
      ST_L1: begin in_seq = 1'b1; exp_pat = P_L2; nxt_state = ST_L2; end
      ST_L2: begin in_seq = 1'b1; exp_pat = P_L3; nxt_state = ST_L3; end
      ST_L3: begin in_seq = 1'b1; fin = 1'b1; fin_mode = MODE_LEFT; end
      ST_R1: begin in_seq = 1'b1; exp_pat = P_R2; nxt_state = ST_R2; end
      ST_R2: begin in_seq = 1'b1; exp_pat = P_R3; nxt_state = ST_R3; end
      ST_R3: begin in_seq = 1'b1; fin = 1'b1; fin_mode = MODE_RIGHT; end
      ST_H1: begin in_seq = 1'b1; fin = 1'b1; fin_mode = MODE_HAZ; end
      default: state_d = ST_SYNC;
    endcase

    if (in_seq) begin
      if (tl.y == exp_pat) begin
        state_d = nxt_state;
        if (fin) begin
          done_d = 1'b1;
          mode_d = fin_mode;
        end
      end else begin
        flag_err = 1'b1;
      end
    end

    // A truncated sequence (dark too early) is already at a sequence boundary, so resume in IDLE.
    if (flag_err) begin
      err_d = 1'b1;
      if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
      state_d = (tl.y == P_DARK) ? ST_IDLE : ST_SYNC;
    end

    // Only dark samples taken while staying in IDLE are counted.
    if (state_q != ST_IDLE || state_d != ST_IDLE) dark_d = 4'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SYNC;
      dark_q    <= 4'd0;
      mode_q    <= MODE_OFF;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dark_q    <= dark_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign tl.mode    = mode_q;
  assign tl.done    = done_q;
  assign tl.err     = err_q;
  assign tl.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_tail_light_decoder.sv
// Bench for tail_light_decoder: directed vector table, hand-written reset/saturation sequences,
// and randomized traffic checked against a sequence-prefix reference model.
module tb_tail_light_decoder;
  localparam int OFF_CYCLES = 2;
  localparam int CNT_W      = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tail_light_decoder_if #(.CNT_W(CNT_W)) tl();

  tail_light_decoder #(.OFF_CYCLES(OFF_CYCLES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .tl    (tl)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0]  y;
    logic [11:0] exp;
  } vec_t;
  vec_t vec[$];

  // Legal sequences as pattern lists; index+1 is the mode code.
  logic [5:0] seq_pat [3][3];
  int         seq_len [3];

  // Reference model state
  bit         m_sync;
  logic [5:0] m_pre[$];
  int         m_dark;
  int         m_mode;
  int         m_cnt;
  bit         m_done;
  bit         m_err;

  function automatic logic [11:0] pk(bit d, bit e, int m, int c);
    logic [1:0] mm;
    logic [7:0] cc;
    mm = m[1:0];
    cc = c[7:0];
    return {d, e, mm, cc};
  endfunction

  function automatic logic [11:0] obs();
    return {tl.done, tl.err, tl.mode, tl.err_cnt};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got done=%b err=%b mode=%b cnt=%0d, expected done=%b err=%b mode=%b cnt=%0d",
               name, act[11], act[10], act[9:8], act[7:0], exp[11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  task automatic step(input logic [5:0] y, input logic [11:0] exp, input string name);
    tl.y = y;
    @(posedge clk);
    #1;
    check(name, obs(), exp);
  endtask

  function automatic void v(logic [5:0] y, bit d, bit e, int m, int c);
    vec_t r;
    r.y   = y;
    r.exp = pk(d, e, m, c);
    vec.push_back(r);
  endfunction

  // Returns the sequence the collected prefix belongs to (whole sequence if full), or -1.
  function automatic int seq_match(bit full);
    for (int t = 0; t < 3; t++) begin
      bit ok;
      ok = (m_pre.size() <= seq_len[t]) && (!full || m_pre.size() == seq_len[t]);
      for (int i = 0; i < m_pre.size() && ok; i++)
        if (m_pre[i] != seq_pat[t][i]) ok = 0;
      if (ok) return t;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_sync = 0;
    m_pre.delete();
    m_dark = 0;
    m_mode = 0;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic [5:0] y);
    int t;
    m_done = 0;
    m_err  = 0;
    if (!m_sync) begin
      if (y == 6'd0) begin m_sync = 1; m_dark = 0; end
    end else if (y != 6'd0) begin
      m_pre.push_back(y);
      m_dark = 0;
      if (seq_match(0) < 0) begin
        m_err  = 1;
        m_sync = 0;
        m_pre.delete();
      end
    end else if (m_pre.size() == 0) begin
      if (m_dark < OFF_CYCLES - 1) begin
        m_dark++;
        if (m_dark == OFF_CYCLES - 1) m_mode = 0;
      end
    end else begin
      t = seq_match(1);
      if (t >= 0) begin m_done = 1; m_mode = t + 1; end
      else m_err = 1;
      m_pre.delete();
      m_dark = 0;
    end
    if (m_err && m_cnt < (1 << CNT_W) - 1) m_cnt++;
  endtask

  task automatic rstep(input logic [5:0] y, input string name);
    model_step(y);
    step(y, pk(m_done, m_err, m_mode, m_cnt), name);
  endtask

  task automatic pulse_reset(input string name);
    #2 reset = 1'b0;
    #1 check(name, obs(), 12'd0);
    #1 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [5:0] pool [8];
    int cyc;
    int r;
    int t;

    seq_pat[0][0] = 6'b001000; seq_pat[0][1] = 6'b011000; seq_pat[0][2] = 6'b111000; seq_len[0] = 3;
    seq_pat[1][0] = 6'b000100; seq_pat[1][1] = 6'b000110; seq_pat[1][2] = 6'b000111; seq_len[1] = 3;
    seq_pat[2][0] = 6'b111111; seq_pat[2][1] = 6'b000000; seq_pat[2][2] = 6'b000000; seq_len[2] = 1;
    pool = '{6'b000000, 6'b001000, 6'b011000, 6'b111000, 6'b000100, 6'b000110, 6'b000111, 6'b111111};

    // Steady LEFT x3
    v(6'b000000,0,0,0,0);
    for (int k = 0; k < 3; k++) begin
      v(6'b001000,0,0,(k==0)?0:1,0); v(6'b011000,0,0,(k==0)?0:1,0);
      v(6'b111000,0,0,(k==0)?0:1,0); v(6'b000000,1,0,1,0);
    end
    // RIGHT then held dark
    v(6'b000100,0,0,1,0); v(6'b000110,0,0,1,0); v(6'b000111,0,0,1,0); v(6'b000000,1,0,2,0);
    v(6'b000000,0,0,0,0); v(6'b000000,0,0,0,0); v(6'b000000,0,0,0,0); v(6'b000000,0,0,0,0);
    // HAZARD x2 then LEFT
    v(6'b111111,0,0,0,0); v(6'b000000,1,0,3,0); v(6'b111111,0,0,3,0); v(6'b000000,1,0,3,0);
    v(6'b001000,0,0,3,0); v(6'b011000,0,0,3,0); v(6'b111000,0,0,3,0); v(6'b000000,1,0,1,0);
    // Illegal order, resync, then LEFT
    v(6'b001000,0,0,1,0); v(6'b000110,0,1,1,1); v(6'b011000,0,0,1,1); v(6'b000000,0,0,1,1);
    v(6'b001000,0,0,1,1); v(6'b011000,0,0,1,1); v(6'b111000,0,0,1,1); v(6'b000000,1,0,1,1);
    // Truncated sequence, repeated pattern
    v(6'b000100,0,0,1,1); v(6'b000000,0,1,1,2); v(6'b001000,0,0,1,2); v(6'b001000,0,1,1,3);
    v(6'b000000,0,0,1,3); v(6'b000000,0,0,0,3);
    // Illegal pattern in IDLE, repeated hazard
    v(6'b010101,0,1,0,4); v(6'b001000,0,0,0,4); v(6'b000000,0,0,0,4); v(6'b111111,0,0,0,4);
    v(6'b111111,0,1,0,5); v(6'b000000,0,0,0,5); v(6'b111111,0,0,0,5); v(6'b000000,1,0,3,5);

    reset = 1'b0;
    tl.y  = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs(), 12'd0);
    reset = 1'b1;

    for (int i = 0; i < vec.size(); i++)
      step(vec[i].y, vec[i].exp, $sformatf("vec%0d", i));

    // Reset asserted while in L2 must abandon the sequence.
    step(6'b001000, pk(0,0,3,5), "mid_l1");
    step(6'b011000, pk(0,0,3,5), "mid_l2");
    pulse_reset("mid_reset_async");
    step(6'b111000, pk(0,0,0,0), "post_rst_sync");
    step(6'b000000, pk(0,0,0,0), "post_rst_nodone");
    step(6'b001000, pk(0,0,0,0), "post_rst_l1");
    step(6'b011000, pk(0,0,0,0), "post_rst_l2");
    step(6'b111000, pk(0,0,0,0), "post_rst_l3");
    step(6'b000000, pk(1,0,1,0), "post_rst_done");

    // Randomized traffic, mostly legal sequences with corruptions and occasional resets.
    pulse_reset("rand_reset");
    cyc = 0;
    while (cyc < 4000) begin
      r = $urandom_range(0, 19);
      if (r < 12) begin
        t = $urandom_range(0, 2);
        if ($urandom_range(0, 3) == 0)
          for (int z = $urandom_range(0, 3); z > 0; z--) begin rstep(6'd0, "rand"); cyc++; end
        for (int i = 0; i < seq_len[t]; i++) begin rstep(seq_pat[t][i], "rand"); cyc++; end
        rstep(6'd0, "rand"); cyc++;
      end else if (r < 17) begin
        rstep(pool[$urandom_range(0, 7)], "rand"); cyc++;
      end else if (r < 19) begin
        rstep(6'($urandom), "rand"); cyc++;
      end else if ($urandom_range(0, 9) == 0) begin
        pulse_reset("rand_reset");
      end
    end

    // Saturation: 300 errors must leave the counter at all-ones.
    pulse_reset("sat_reset");
    rstep(6'd0, "sat_sync");
    for (int k = 0; k < 300; k++) begin
      rstep(6'b010101, "sat_err");
      rstep(6'd0, "sat_resync");
    end
    n_chk++;
    if (tl.err_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL sat_final: err_cnt=%0d expected 255", tl.err_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
